// File: rtl/bufferm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bufferm_ctrl_pkg
//  Description : Shared definitions for the bufferM read controller: FSM
//                state encoding and skid FIFO sizing constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package bufferm_ctrl_pkg;

    // Depth of the output skid FIFO. Two entries cover the one-cycle bufferM
    // read latency so the controller can stream one word per cycle.
    localparam int SKID_DEPTH = 2;

    // Width of an occupancy counter able to hold 0..SKID_DEPTH.
    localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bufferm_skid_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : bufferm_skid_fifo
//  Description : Small synchronous FIFO buffering words returned by bufferM
//                until the consumer accepts them. The head word is presented
//                combinationally on head_data.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk        : clock, rising edge
//    reset      : synchronous active-high reset, empties the FIFO
//    push       : write push_data this cycle
//    push_data  : word to store
//    pop        : remove the head word this cycle
//    head_data  : current head word (stale/zero when empty)
//    full       : FIFO holds SKID_DEPTH words
//    empty      : FIFO holds no words
//    count      : current occupancy
// ============================================================================
module bufferm_skid_fifo
    import bufferm_ctrl_pkg::*;
#(
    parameter int dataLen = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [dataLen-1:0]    push_data,
    input  logic                  pop,
    output logic [dataLen-1:0]    head_data,
    output logic                  full,
    output logic                  empty,
    output logic [SKID_CNT_W-1:0] count
);

    // Pointers wrap naturally because SKID_DEPTH is a power of two.
    localparam int c_PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;

    logic [dataLen-1:0]    r_mem [SKID_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [SKID_CNT_W-1:0] r_count;

    logic w_push_en;
    logic w_pop_en;

    assign empty     = (r_count == '0);
    assign full      = (r_count == SKID_CNT_W'(SKID_DEPTH));
    assign count     = r_count;
    assign head_data = r_mem[r_rd_ptr];

    // A push into a full FIFO is only accepted when a pop frees a slot in
    // the same cycle.
    assign w_pop_en  = pop && !empty;
    assign w_push_en = push && (!full || w_pop_en);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push_en) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop_en) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push_en, w_pop_en})
                2'b10:   r_count <= r_count + SKID_CNT_W'(1);
                2'b01:   r_count <= r_count - SKID_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/bufferm_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bufferm_rd_ctrl
//  Description : Burst read controller for bufferM. On a start pulse it
//                issues count consecutive read addresses (wrapping modulo
//                2^addrLen), captures the data returned one cycle later into
//                a skid FIFO and delivers it on a valid/ready stream. Reads
//                are only issued when a FIFO slot is guaranteed for the
//                returning word, so nothing is ever dropped.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk        : clock, rising edge
//    reset      : synchronous active-high reset, aborts any burst silently
//    start      : burst request, sampled only while idle
//    base_addr  : first bufferM address of the burst
//    count      : words to read, 0..2^addrLen
//    rd_addr    : read address to bufferM
//    rom_data   : bufferM read data, valid the cycle after rd_addr
//    out_data   : delivered word
//    out_valid  : out_data holds an undelivered word
//    out_ready  : consumer accept
//    busy       : burst in progress
//    done       : one-cycle pulse when a burst completes
// ============================================================================
module bufferm_rd_ctrl
    import bufferm_ctrl_pkg::*;
#(
    parameter int addrLen = 10,
    parameter int dataLen = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [addrLen-1:0] base_addr,
    input  logic [addrLen:0]   count,
    output logic [addrLen-1:0] rd_addr,
    input  logic [dataLen-1:0] rom_data,
    output logic [dataLen-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               done
);

    localparam logic [addrLen-1:0] c_ADDR_ONE   = {{(addrLen-1){1'b0}}, 1'b1};
    localparam logic [addrLen:0]   c_REMAIN_ONE = {{addrLen{1'b0}}, 1'b1};
    // One extra bit so fifo count + in-flight word cannot overflow.
    localparam int                 c_OCC_W      = SKID_CNT_W + 1;

    state_t               r_state;
    state_t               w_next_state;
    logic [addrLen-1:0]   r_addr;
    logic [addrLen:0]     r_remain;
    logic                 r_inflight;
    logic                 r_done;

    logic                 w_issue;
    logic                 w_done_next;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_credit_ok;
    logic [c_OCC_W-1:0]   w_occ;

    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [SKID_CNT_W-1:0] w_fifo_cnt;

    assign rd_addr   = r_addr;
    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign out_valid = !w_fifo_empty;
    assign w_pop     = out_valid && out_ready;

    // Projected FIFO occupancy once the word already in flight lands and
    // this cycle's pop (if any) leaves. A new read is issued only when its
    // data will still find a free slot next cycle.
    assign w_occ       = c_OCC_W'(w_fifo_cnt) + c_OCC_W'(r_inflight) - c_OCC_W'(w_pop);
    assign w_credit_ok = (w_occ < c_OCC_W'(SKID_DEPTH));

    // The credit scheme keeps this push always accepted; the full check only
    // keeps the FIFO consistent if that invariant were ever violated.
    assign w_push = r_inflight && (!w_fifo_full || w_pop);

    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        w_done_next  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        w_next_state = ISSUE;
                    end else begin
                        // Empty burst completes immediately.
                        w_done_next = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (w_credit_ok) begin
                    w_issue = 1'b1;
                    if (r_remain == c_REMAIN_ONE) begin
                        w_next_state = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // No read in flight and nothing left to deliver.
                if (!r_inflight && (w_fifo_cnt == '0)) begin
                    w_next_state = IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_remain   <= '0;
            r_inflight <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_inflight <= w_issue;
            r_done     <= w_done_next;
            if ((r_state == IDLE) && start) begin
                r_addr   <= base_addr;
                r_remain <= count;
            end else if (w_issue) begin
                r_addr   <= r_addr + c_ADDR_ONE;
                r_remain <= r_remain - c_REMAIN_ONE;
            end
        end
    end

    bufferm_skid_fifo #(
        .dataLen (dataLen)
    ) u_skid_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (rom_data),
        .pop       (w_pop),
        .head_data (out_data),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_cnt)
    );

endmodule
`default_nettype wire
